// File: rtl/float_align_pre.sv
// Pre-adder alignment stage: orders two binary32 operands by magnitude and right-shifts the smaller one.
// Optional macro FLOAT_ALIGN_BARREL_EN replaces the serial one-bit-per-cycle shifter with a single-cycle barrel shift.
module float_align_pre #(
  parameter int SHIFT_CAP = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:0] largereg,
  output logic [32:0] smallreg,
  output logic [7:0]  diff,
  output logic        sticky,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid and payload stay stable until that edge, and ready may not depend on valid.

  typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_e;

  localparam logic [7:0] CAP = 8'(SHIFT_CAP);

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        op_q, op_d;
  logic [32:0] large_q, large_d, small_q, small_d;
  logic [7:0]  diff_q, diff_d, cnt_q, cnt_d;
  logic        sticky_q, sticky_d, flush_q, flush_d;

  logic        a_big;
  logic [32:0] pack_a, pack_b;
  logic [7:0]  exp_diff;

  assign pack_a   = {a_q[31], a_q[30:23], (a_q[30:23] != 8'd0), a_q[22:0]};
  assign pack_b   = {b_q[31] ^ op_q, b_q[30:23], (b_q[30:23] != 8'd0), b_q[22:0]};
  // {exp, mant} compares as an unsigned magnitude; ties keep a as the larger operand.
  assign a_big    = (a_q[30:0] >= b_q[30:0]);
  assign exp_diff = a_big ? (a_q[30:23] - b_q[30:23]) : (b_q[30:23] - a_q[30:23]);

`ifdef FLOAT_ALIGN_BARREL_EN
  logic [23:0] lost_mask;
  assign lost_mask = flush_q ? 24'hFF_FFFF : ~(24'hFF_FFFF << cnt_q);
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    large_d  = large_q;
    small_d  = small_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    flush_d  = flush_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        large_d  = a_big ? pack_a : pack_b;
        small_d  = a_big ? pack_b : pack_a;
        diff_d   = exp_diff;
        sticky_d = 1'b0;
        flush_d  = (exp_diff >= CAP);
        cnt_d    = (exp_diff >= CAP) ? CAP : exp_diff;
        state_d  = (exp_diff == 8'd0) ? DONE : SHIFT;
      end
      SHIFT: begin
`ifdef FLOAT_ALIGN_BARREL_EN
        small_d[23:0]  = flush_q ? 24'd0 : (small_q[23:0] >> cnt_q);
        sticky_d       = |(small_q[23:0] & lost_mask);
        small_d[31:24] = large_q[31:24];
        state_d        = DONE;
`else
        small_d[23:0] = small_q[23:0] >> 1;
        sticky_d      = sticky_q | small_q[0];
        cnt_d         = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          // Last step of a capped shift discards whatever is left of the significand.
          if (flush_q) begin
            small_d[23:0] = 24'd0;
            sticky_d      = sticky_q | (|small_q[23:0]);
          end
          small_d[31:24] = large_q[31:24];
          state_d        = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      large_q  <= '0;
      small_q  <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      large_q  <= large_d;
      small_q  <= small_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      flush_q  <= flush_d;
    end
  end

  // Ready is held low while reset is asserted even though the state is already IDLE.
  assign in_ready    = (state_q == IDLE) && rst_n;
  assign out_valid   = (state_q == DONE);
  assign largereg    = large_q;
  assign smallreg    = small_q;
  assign diff        = diff_q;
  assign sticky      = sticky_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_float_align_pre.sv
// Directed bench for float_align_pre: arithmetic reference model, expected queue and per-cycle output compare.
module tb_float_align_pre;

  localparam int SHIFT_CAP = 24;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, op, out_valid, out_ready, sticky;
  logic [31:0] a, b;
  logic [32:0] largereg, smallreg;
  logic [7:0]  diff;
  logic [1:0]  dbg_state;

  float_align_pre #(.SHIFT_CAP(SHIFT_CAP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .largereg(largereg), .smallreg(smallreg), .diff(diff), .sticky(sticky),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [74:0] exp_q[$];
  int          lat_q[$];
  int          hs_q[$];
  bit          lat_done = 1'b0;

  task automatic chk(input string name, input logic [74:0] act, input logic [74:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: {large(33), small(33), diff(8), sticky(1)} from plain integer arithmetic.
  function automatic logic [74:0] model(input logic [31:0] x, input logic [31:0] y, input logic o);
    logic        s_x, s_y, s_l, s_s, st;
    longint      e_x, e_y, f_x, f_y, e_l, e_s, f_l, f_s, d, n, sig_s, kept;
    logic [7:0]  el8, d8;
    logic [22:0] fl23;
    logic [23:0] ks24;
    s_x = x[31];
    s_y = y[31] ^ o;
    e_x = longint'(x[30:23]);
    e_y = longint'(y[30:23]);
    f_x = longint'(x[22:0]);
    f_y = longint'(y[22:0]);
    if (e_x * 8388608 + f_x >= e_y * 8388608 + f_y) begin
      s_l = s_x; e_l = e_x; f_l = f_x; s_s = s_y; e_s = e_y; f_s = f_y;
    end else begin
      s_l = s_y; e_l = e_y; f_l = f_y; s_s = s_x; e_s = e_x; f_s = f_x;
    end
    d     = e_l - e_s;
    n     = (d < SHIFT_CAP) ? d : SHIFT_CAP;
    sig_s = ((e_s != 0) ? 8388608 : 0) + f_s;
    if (d >= SHIFT_CAP) begin
      kept = 0;
      st   = (sig_s != 0);
    end else begin
      kept = sig_s >> n;
      st   = ((kept << n) != sig_s);
    end
    el8  = 8'(e_l);
    d8   = 8'(d);
    fl23 = 23'(f_l);
    ks24 = 24'(kept);
    return {s_l, el8, (e_l != 0), fl23, s_s, el8, ks24, d8, st};
  endfunction

  function automatic int lat_of(input logic [74:0] m);
    int d;
    d = int'(m[8:1]);
`ifdef FLOAT_ALIGN_BARREL_EN
    return (d == 0) ? 2 : 3;
`else
    return ((d < SHIFT_CAP) ? d : SHIFT_CAP) + 2;
`endif
  endfunction

  // Compare process: while out_valid is up, the outputs must match the head of the queue every cycle.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_valid: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        if (!lat_done) begin
          chk("latency", 75'(cyc - hs_q[0]), 75'(lat_q[0]));
          lat_done = 1'b1;
        end
        chk("result", {largereg, smallreg, diff, sticky}, exp_q[0]);
        chk("busy_in_ready", 75'(in_ready), 75'(0));
        if (out_ready === 1'b1) begin
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
          void'(hs_q.pop_front());
          lat_done = 1'b0;
        end
      end
    end
  end

  task automatic accept(input logic [31:0] ta, input logic [31:0] tb, input logic top);
    int n;
    logic [74:0] m;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("accept_ready", 75'(in_ready), 75'(1));
    a = ta; b = tb; op = top; in_valid = 1'b1;
    m = model(ta, tb, top);
    exp_q.push_back(m);
    lat_q.push_back(lat_of(m));
    hs_q.push_back(cyc);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic top,
                        input int hold, input bit keep_valid);
    int n;
    accept(ta, tb, top);
    in_valid = keep_valid;
    a  = $urandom;
    b  = $urandom;
    op = 1'($urandom_range(0, 1));
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("done_reached", 75'(out_valid), 75'(1));
    if (out_valid !== 1'b1) begin
      exp_q.delete(); lat_q.delete(); hs_q.delete(); lat_done = 1'b0;
      return;
    end
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_in_ready", 75'(in_ready), 75'(0));
      chk("hold_out_valid", 75'(out_valid), 75'(1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_in_ready", 75'(in_ready), 75'(1));
    chk("post_hs_out_valid", 75'(out_valid), 75'(0));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;

    // Hand-computed expectations that pin the model.
    chk("pin_3p0_1p0", model(32'h40400000, 32'h3F800000, 1'b0),
        {33'h080C00000, 33'h080400000, 8'd1, 1'b0});
    chk("pin_swap", model(32'h3F800000, 32'h40400000, 1'b0),
        {33'h080C00000, 33'h080400000, 8'd1, 1'b0});
    chk("pin_sub_tie", model(32'h3F800000, 32'h3F800000, 1'b1),
        {33'h07F800000, 33'h17F800000, 8'd0, 1'b0});
    chk("pin_diff24", model(32'h4B800000, 32'h3F800001, 1'b0),
        {33'h097800000, 33'h097000000, 8'd24, 1'b1});
    chk("pin_diff23", model(32'h4B000001, 32'h3F800001, 1'b0),
        {33'h096800001, 33'h096000001, 8'd23, 1'b1});
`ifdef FLOAT_ALIGN_BARREL_EN
    chk("pin_lat24", 75'(lat_of(model(32'h4B800000, 32'h3F800001, 1'b0))), 75'(3));
`else
    chk("pin_lat24", 75'(lat_of(model(32'h4B800000, 32'h3F800001, 1'b0))), 75'(26));
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {largereg, smallreg, diff, sticky}, 75'(0));
    chk("rst_out_valid", 75'(out_valid), 75'(0));
    chk("rst_in_ready", 75'(in_ready), 75'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_ready", 75'(in_ready), 75'(1));

    run_op(32'h40400000, 32'h3F800000, 1'b0, 0, 1'b0);
    run_op(32'h3F800000, 32'h40400000, 1'b0, 0, 1'b0);
    run_op(32'h3F800000, 32'h3F800000, 1'b1, 0, 1'b0);
    run_op(32'h4B800000, 32'h3F800001, 1'b0, 0, 1'b0);
    run_op(32'h4B000001, 32'h3F800001, 1'b0, 1, 1'b0);
    run_op(32'hC0400000, 32'h3F800000, 1'b1, 0, 1'b0);
    run_op(32'h3F800000, 32'h40400000, 1'b1, 0, 1'b1);
    run_op(32'h42000000, 32'h3FFFFFFF, 1'b0, 0, 1'b0);
    run_op(32'h00000003, 32'h00000001, 1'b0, 0, 1'b0);
    run_op(32'h4F000000, 32'h3F800000, 1'b0, 0, 1'b0);
    run_op(32'h00000000, 32'h4B000001, 1'b1, 0, 1'b0);
    run_op(32'h4B800000, 32'h3F800000, 1'b0, 0, 1'b0);

    // Downstream stall in DONE with in_valid kept high throughout the operation.
    run_op(32'h40400000, 32'h3F800000, 1'b0, 5, 1'b1);

    // Reset in the middle of the shift aborts the operation.
    accept(32'h4B800000, 32'h3F800001, 1'b0);
    in_valid = 1'b0;
`ifdef FLOAT_ALIGN_BARREL_EN
    @(posedge clk); #1;
`else
    repeat (5) begin @(posedge clk); #1; end
`endif
    chk("abort_in_shift", 75'(dbg_state), 75'(2));
    chk("abort_pre_valid", 75'(out_valid), 75'(0));
    rst_n = 1'b0;
    exp_q.delete(); lat_q.delete(); hs_q.delete(); lat_done = 1'b0;
    @(posedge clk); #1;
    chk("abort_outputs", {largereg, smallreg, diff, sticky}, 75'(0));
    chk("abort_out_valid", 75'(out_valid), 75'(0));
    chk("abort_in_ready", 75'(in_ready), 75'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready_after", 75'(in_ready), 75'(1));
    run_op(32'h3F800000, 32'h40400000, 1'b0, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 75'(exp_q.size()), 75'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
